// File: rtl/uart_tx_pkg.sv
// Shared definitions for the UART transmitter: data/counter widths, FSM state
// encodings and the bit-period computation.
// Optional feature macro: UART_TX_PARITY_EN adds the PARITY state.
package uart_tx_pkg;

    localparam int unsigned DATA_W = 8;
    localparam int unsigned CNT_W  = 16;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_STOP   = 3'd3
`ifdef UART_TX_PARITY_EN
        , ST_PARITY = 3'd4
`endif
    } uart_state_e;

    // Integer clocks per bit; the remainder is dropped.
    function automatic int unsigned clks_per_bit(input int unsigned clk_freq,
                                                 input int unsigned baud_rate);
        return clk_freq / baud_rate;
    endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period timer shared by the UART transmitter and receiver.
// Ports:
//   clk      in  clock
//   rst_n    in  asynchronous active-low reset
//   restart  in  forces the count back to 0 on the next edge (frame start)
//   bit_done out registered pulse on the last cycle of every bit period
module uart_baud_gen
    import uart_tx_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 434
) (
    input  logic clk,
    input  logic rst_n,
    input  logic restart,
    output logic bit_done
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_nxt;

    // Count 0..LAST and wrap; restart aligns the count to a new frame.
    always_comb begin
        cnt_nxt = cnt_q + CNT_W'(1);
        if (restart || (cnt_q == LAST)) begin
            cnt_nxt = '0;
        end
    end

    // bit_done is registered from the next count so it is high while cnt_q == LAST.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q    <= '0;
            bit_done <= 1'b0;
        end else begin
            cnt_q    <= cnt_nxt;
            bit_done <= (cnt_nxt == LAST);
        end
    end

endmodule

// File: rtl/uart_tx.sv
// 8-N-1 UART transmitter with a one-byte holding register; back-to-back bytes
// are sent without an idle gap. LSB first, idle-high line.
// Optional feature macro: UART_TX_PARITY_EN inserts a parity bit after bit 7
// (even parity when PARITY_ODD=0, odd when PARITY_ODD=1).
// Ports:
//   clk       in   clock
//   rst_n     in   asynchronous active-low reset
//   tx_data   in   byte to send, sampled on accept
//   tx_valid  in   tx_data valid
//   tx_ready  out  holding register empty (accept = tx_valid && tx_ready)
//   tx        out  registered serial line
//   tx_busy   out  a frame is on the line
module uart_tx
    import uart_tx_pkg::*;
#(
    parameter int unsigned CLK_FREQ   = 50000000,
    parameter int unsigned BAUD_RATE  = 115200,
    parameter int unsigned STOP_BITS  = 1,
    parameter int unsigned PARITY_ODD = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic              tx,
    output logic              tx_busy
);

    localparam int unsigned CLKS_PER_BIT = clks_per_bit(CLK_FREQ, BAUD_RATE);

    // Elaboration-time parameter range checks.
    if ((CLKS_PER_BIT < 2) || (CLKS_PER_BIT > (1 << CNT_W))) begin : g_bad_clks
        $error("uart_tx: CLKS_PER_BIT must be in 2..65536");
    end
    if ((STOP_BITS != 1) && (STOP_BITS != 2)) begin : g_bad_stop
        $error("uart_tx: STOP_BITS must be 1 or 2");
    end
    if (PARITY_ODD > 1) begin : g_bad_parity
        $error("uart_tx: PARITY_ODD must be 0 or 1");
    end

    uart_state_e       state_q;
    uart_state_e       state_nxt;
    logic [DATA_W-1:0] sr_q;
    logic [DATA_W-1:0] sr_nxt;
    logic [DATA_W-1:0] hold_q;
    logic              hold_full_q;
    logic              hold_full_nxt;
    logic [2:0]        bit_idx_q;
    logic              stop_cnt_q;
    logic              bit_done;
    logic              accept;
    logic              last_data;
    logic              final_stop;
    logic              load_sr;
    logic              hold_write;
    logic              tx_nxt;
    logic              busy_nxt;
    logic              ready_nxt;
`ifdef UART_TX_PARITY_EN
    logic              par_q;
    logic              par_nxt;
`endif

    uart_baud_gen #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_baud (
        .clk      (clk),
        .rst_n    (rst_n),
        .restart  (load_sr),
        .bit_done (bit_done)
    );

    // Handshake and frame-boundary decode.
    always_comb begin
        accept     = tx_valid && tx_ready;
        last_data  = (state_q == ST_DATA) && bit_done && (bit_idx_q == 3'd7);
        final_stop = (state_q == ST_STOP) && bit_done && (stop_cnt_q == 1'(STOP_BITS - 1));
        // A new frame starts from idle, or straight after the last stop bit when
        // a byte is held or arrives on that very edge.
        load_sr    = ((state_q == ST_IDLE) && accept) ||
                     (final_stop && (hold_full_q || accept));
        hold_write = accept && (state_q != ST_IDLE) && !final_stop;
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (accept) state_nxt = ST_START;
            end
            ST_START: begin
                if (bit_done) state_nxt = ST_DATA;
            end
            ST_DATA: begin
`ifdef UART_TX_PARITY_EN
                if (last_data) state_nxt = ST_PARITY;
`else
                if (last_data) state_nxt = ST_STOP;
`endif
            end
`ifdef UART_TX_PARITY_EN
            ST_PARITY: begin
                if (bit_done) state_nxt = ST_STOP;
            end
`endif
            ST_STOP: begin
                if (final_stop) state_nxt = load_sr ? ST_START : ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Datapath next values and registered-output next values.
    always_comb begin
        sr_nxt = sr_q;
        if (load_sr) begin
            sr_nxt = hold_full_q ? hold_q : tx_data;
        end else if ((state_q == ST_DATA) && bit_done) begin
            sr_nxt = {1'b0, sr_q[DATA_W-1:1]};
        end

        hold_full_nxt = hold_full_q;
        if (hold_write) begin
            hold_full_nxt = 1'b1;
        end else if (final_stop && hold_full_q) begin
            hold_full_nxt = 1'b0;
        end

`ifdef UART_TX_PARITY_EN
        // Parity is taken from the whole byte at load, before shifting starts.
        par_nxt = par_q;
        if (load_sr) begin
            par_nxt = (^sr_nxt) ^ 1'(PARITY_ODD);
        end
`endif

        busy_nxt  = (state_nxt != ST_IDLE);
        ready_nxt = !hold_full_nxt;
        tx_nxt    = 1'b1;
        unique case (state_nxt)
            ST_START:  tx_nxt = 1'b0;
            ST_DATA:   tx_nxt = sr_nxt[0];
`ifdef UART_TX_PARITY_EN
            ST_PARITY: tx_nxt = par_nxt;
`endif
            default:   tx_nxt = 1'b1;
        endcase
    end

    // Datapath and output registers; tx idles high straight out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr_q        <= '0;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            bit_idx_q   <= '0;
            stop_cnt_q  <= 1'b0;
            tx          <= 1'b1;
            tx_busy     <= 1'b0;
            tx_ready    <= 1'b0;
`ifdef UART_TX_PARITY_EN
            par_q       <= 1'b0;
`endif
        end else begin
            sr_q        <= sr_nxt;
            hold_full_q <= hold_full_nxt;
            if (hold_write) begin
                hold_q <= tx_data;
            end
            if (load_sr) begin
                bit_idx_q <= '0;
            end else if ((state_q == ST_DATA) && bit_done) begin
                bit_idx_q <= bit_idx_q + 3'd1;
            end
            if ((state_q == ST_STOP) && bit_done) begin
                stop_cnt_q <= final_stop ? 1'b0 : (stop_cnt_q + 1'b1);
            end
            tx       <= tx_nxt;
            tx_busy  <= busy_nxt;
            tx_ready <= ready_nxt;
`ifdef UART_TX_PARITY_EN
            par_q    <= par_nxt;
`endif
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// Directed self-checking bench for uart_tx at 50 MHz / 115200 baud (434 clk/bit).
// Also honours UART_TX_PARITY_EN for the frame layout and the parity vector.
module tb_uart_tx;

    localparam int unsigned CPB     = 434;
    localparam int unsigned PAR_ODD = 0;
`ifdef UART_TX_PARITY_EN
    localparam int unsigned NBITS   = 11;
`else
    localparam int unsigned NBITS   = 10;
`endif
    localparam int unsigned FRAME   = NBITS * CPB;

    logic       clk      = 1'b0;
    logic       rst_n    = 1'b0;
    logic [7:0] tx_data  = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready;
    logic       tx;
    logic       tx_busy;

    int          n_checks = 0;
    int          n_fail   = 0;
    int unsigned cyc      = 0;

    uart_tx #(
        .CLK_FREQ   (50000000),
        .BAUD_RATE  (115200),
        .STOP_BITS  (1),
        .PARITY_ODD (PAR_ODD)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .tx       (tx),
        .tx_busy  (tx_busy)
    );

    always #10 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected line level for frame bit k of byte b (0 = start bit).
    function automatic logic exp_bit(input logic [7:0] b, input int k);
        if (k == 0) return 1'b0;
        if (k <= 8) return b[k-1];
`ifdef UART_TX_PARITY_EN
        if (k == 9) return (^b) ^ 1'(PAR_ODD);
`endif
        return 1'b1;
    endfunction

    // Called right after the frame's start edge; checks every cycle of every bit.
    task automatic frame_check(input logic [7:0] b, input string tag);
        int busy_bad;
        busy_bad = 0;
        for (int k = 0; k < int'(NBITS); k++) begin
            int bad;
            logic e;
            bad = 0;
            e   = exp_bit(b, k);
            for (int c = 0; c < int'(CPB); c++) begin
                if (tx !== e) bad++;
                if (tx_busy !== 1'b1) busy_bad++;
                tick();
            end
            check($sformatf("%s bit%0d bad cycles", tag, k), bad, 0);
        end
        check($sformatf("%s busy low cycles", tag), busy_bad, 0);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (tx_busy !== 1'b0 && n < int'(3 * FRAME)) begin
            tick();
            n++;
        end
    endtask

    logic [7:0]  lb [3] = '{8'h00, 8'hFF, 8'h81};
    logic [7:0]  rxq [$];
    int unsigned t0;
    int unsigned t1;
    int          ferr;

    initial begin
        // Reset values and release.
        tick();
        tick();
        check("rst tx", tx, 1);
        check("rst busy", tx_busy, 0);
        check("rst ready", tx_ready, 0);
        rst_n = 1'b1;
        check("release ready", tx_ready, 0);
        tick();
        check("ready after release", tx_ready, 1);

        // Single byte 0x55 from idle.
        tx_data  = 8'h55;
        tx_valid = 1'b1;
        tick();
        tx_valid = 1'b0;
        check("a ready after accept", tx_ready, 1);
        frame_check(8'h55, "a");
        check("a idle tx", tx, 1);
        check("a busy drop", tx_busy, 0);

        // 0xA5 then 0x3C with tx_valid held.
        tx_data  = 8'hA5;
        tx_valid = 1'b1;
        tick();
        t0 = cyc;
        fork
            begin
                int n;
                tx_data = 8'h3C;
                tick();
                tx_valid = 1'b0;
                check("b ready low", tx_ready, 0);
                n = 0;
                while (tx_ready !== 1'b1 && n < int'(3 * FRAME)) begin
                    tick();
                    n++;
                end
                check("b ready rise cycle", cyc - t0, FRAME);
            end
            begin
                frame_check(8'hA5, "b0");
                frame_check(8'h3C, "b1");
            end
        join
        check("b idle busy", tx_busy, 0);

        // Backpressure: third byte waits for the holding register; junk on
        // tx_data while tx_ready=0 must be ignored.
        tx_data  = 8'h11;
        tx_valid = 1'b1;
        tick();
        t0 = cyc;
        fork
            begin
                int n;
                tx_data = 8'h22;
                tick();
                n = 0;
                while (tx_ready !== 1'b1 && n < int'(3 * FRAME)) begin
                    tx_data = 8'(n) ^ 8'hC3;
                    tick();
                    n++;
                end
                t1 = cyc;
                tx_data = 8'h33;
                tick();
                tx_valid = 1'b0;
                check("c ready rise cycle", t1 - t0, FRAME);
            end
            begin
                frame_check(8'h11, "c0");
                frame_check(8'h22, "c1");
                frame_check(8'h33, "c2");
            end
        join
        check("c idle busy", tx_busy, 0);

        // Reset pulse in the middle of DATA bit 1 of 0xF0.
        tx_data  = 8'hF0;
        tx_valid = 1'b1;
        tick();
        tx_valid = 1'b0;
        repeat (2 * CPB + 100) tick();
        check("d mid data tx", tx, 0);
        #3 rst_n = 1'b0;
        #1;
        check("d async tx", tx, 1);
        check("d async busy", tx_busy, 0);
        check("d async ready", tx_ready, 0);
        tick();
        tick();
        rst_n = 1'b1;
        check("d release ready", tx_ready, 0);
        tick();
        check("d ready back", tx_ready, 1);
        begin
            int bad;
            bad = 0;
            repeat (FRAME + CPB) begin
                if (tx !== 1'b1 || tx_busy !== 1'b0) bad++;
                tick();
            end
            check("d residual cycles", bad, 0);
        end

        // Loopback through a mid-bit sampling receiver model.
        ferr = 0;
        fork
            begin
                for (int i = 0; i < 3; i++) begin
                    int n;
                    logic r;
                    tx_data  = lb[i];
                    tx_valid = 1'b1;
                    n = 0;
                    do begin
                        r = tx_ready;
                        tick();
                        n++;
                    end while (!r && n < int'(3 * FRAME));
                end
                tx_valid = 1'b0;
            end
            begin
                for (int f = 0; f < 3; f++) begin
                    int n;
                    logic [7:0] rx;
                    n = 0;
                    while (tx !== 1'b0 && n < int'(3 * FRAME)) begin
                        tick();
                        n++;
                    end
                    repeat (CPB / 2) tick();
                    if (tx !== 1'b0) ferr++;
                    for (int k = 0; k < 8; k++) begin
                        repeat (CPB) tick();
                        rx[k] = tx;
                    end
`ifdef UART_TX_PARITY_EN
                    repeat (CPB) tick();
`endif
                    repeat (CPB) tick();
                    if (tx !== 1'b1) ferr++;
                    rxq.push_back(rx);
                end
            end
        join
        check("e rx count", rxq.size(), 3);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("e rx byte%0d", i), (i < rxq.size()) ? rxq[i] : 8'hxx, lb[i]);
        end
        check("e framing errors", ferr, 0);
        wait_idle();
        check("e idle busy", tx_busy, 0);

`ifdef UART_TX_PARITY_EN
        // 0x07 has three ones: even parity bit 1, odd parity bit 0.
        tx_data  = 8'h07;
        tx_valid = 1'b1;
        tick();
        tx_valid = 1'b0;
        fork
            begin
                repeat (9 * CPB + CPB / 2) tick();
                check("p parity bit", tx, (PAR_ODD == 0) ? 1 : 0);
            end
            frame_check(8'h07, "p");
        join
        check("p busy drop after 11 bits", tx_busy, 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
